jtag_tap_ctrl: RTL and testbench

- Parametrised JTAG TAP controller.
- Contains:
  - the 16-state TMS-driven state machine;
  - an IR of configurable width;
  - BYPASS, IDCODE and one user data register of configurable width.
- Shifts TDI to TDO in a single clock domain.
- Exposes the user DR through a capture/update interface to on-chip debug logic.

---
 rtl/jtag_pkg.sv | 33 +++
 rtl/jtag_tap_fsm.sv | 42 ++++
 rtl/jtag_tap_ctrl.sv | 151 +++++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP types: 16-state encoding and DR select codes.
// Used by jtag_tap_fsm and jtag_tap_ctrl.
package jtag_pkg;

  localparam int TAP_STATE_W = 4;
  localparam int IDCODE_W    = 32;

  typedef enum logic [TAP_STATE_W-1:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PAU_DR = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PAU_IR = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_t;

  typedef enum logic [1:0] {
    SEL_BYP = 2'd0,
    SEL_ID  = 2'd1,
    SEL_USR = 2'd2
  } dr_sel_t;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state machine, TMS sampled on CLK rising edge.
// Pure next-state table; synchronous active-high RESET.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       tms,
  output tap_state_t state
);

  tap_state_t nxt;

  always_ff @(posedge CLK) begin
    if (RESET) state <= TLR;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      TLR:    nxt = tms ? TLR    : RTI;
      RTI:    nxt = tms ? SEL_DR : RTI;
      SEL_DR: nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR: nxt = tms ? EX1_DR : SH_DR;
      SH_DR:  nxt = tms ? EX1_DR : SH_DR;
      EX1_DR: nxt = tms ? UPD_DR : PAU_DR;
      PAU_DR: nxt = tms ? EX2_DR : PAU_DR;
      EX2_DR: nxt = tms ? UPD_DR : SH_DR;
      UPD_DR: nxt = tms ? SEL_DR : RTI;
      SEL_IR: nxt = tms ? TLR    : CAP_IR;
      CAP_IR: nxt = tms ? EX1_IR : SH_IR;
      SH_IR:  nxt = tms ? EX1_IR : SH_IR;
      EX1_IR: nxt = tms ? UPD_IR : PAU_IR;
      PAU_IR: nxt = tms ? EX2_IR : PAU_IR;
      EX2_IR: nxt = tms ? UPD_IR : SH_IR;
      UPD_IR: nxt = tms ? SEL_DR : RTI;
      default: nxt = TLR;
    endcase
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: IR, BYPASS, optional IDCODE, user DR.
// IDCODE register present only when JTAG_TAP_IDCODE_EN is defined.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH      = 4,
  parameter int                  USER_DR_WIDTH = 8,
  parameter logic [IDCODE_W-1:0] IDCODE        = 32'h1BA0_1477,
  parameter int                  IDCODE_INSTR  = 1,
  parameter int                  USER_INSTR    = 8
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     tms,
  input  logic                     tdi,
  output logic                     tdo,
  output logic                     tdo_en,
  output logic [TAP_STATE_W-1:0]   state,
  output logic [IR_WIDTH-1:0]      ir,
  input  logic [USER_DR_WIDTH-1:0] dr_capture_data,
  output logic [USER_DR_WIDTH-1:0] dr_update_data,
  output logic                     dr_update_strobe
);

  localparam logic [IR_WIDTH-1:0] IR_BYP = '1;
  localparam logic [IR_WIDTH-1:0] IR_USR = IR_WIDTH'(USER_INSTR);
  localparam logic [IR_WIDTH-1:0] IR_CAP = IR_WIDTH'(2'b01);
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_ID  = IR_WIDTH'(IDCODE_INSTR);
  localparam logic [IR_WIDTH-1:0] IR_RST = IR_ID;
`else
  localparam logic [IR_WIDTH-1:0] IR_RST = IR_BYP;
`endif

  // all-ones always means BYPASS, even if it collides with another code
  function automatic dr_sel_t decode(input logic [IR_WIDTH-1:0] c);
    if (c == IR_BYP) return SEL_BYP;
`ifdef JTAG_TAP_IDCODE_EN
    if (c == IR_ID)  return SEL_ID;
`endif
    if (c == IR_USR) return SEL_USR;
    return SEL_BYP;
  endfunction

  tap_state_t               st;
  logic [IR_WIDTH-1:0]      ir_q;
  logic [IR_WIDTH-1:0]      ir_sh;
  dr_sel_t                  sel;
  logic                     byp;
  logic [USER_DR_WIDTH-1:0] usr_sh;
  logic [USER_DR_WIDTH-1:0] usr_nx;
  logic [USER_DR_WIDTH-1:0] upd_q;
  logic                     stb_q;
`ifdef JTAG_TAP_IDCODE_EN
  logic [IDCODE_W-1:0]      id_sh;
`else
  logic                     unused_id;
  assign unused_id = ^{IDCODE, IDCODE_INSTR};
`endif

  jtag_tap_fsm u_fsm (
    .CLK   (CLK),
    .RESET (RESET),
    .tms   (tms),
    .state (st)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ir_q  <= IR_RST;
      ir_sh <= '0;
    end else begin
      case (st)
        TLR:    ir_q  <= IR_RST;
        CAP_IR: ir_sh <= IR_CAP;
        SH_IR:  ir_sh <= {tdi, ir_sh[IR_WIDTH-1:1]};
        UPD_IR: ir_q  <= ir_sh;
        default: ;
      endcase
    end
  end

  always_comb begin
    usr_nx = usr_sh >> 1;
    usr_nx[USER_DR_WIDTH-1] = tdi;
  end

  // selection is latched at capture so an IR change waits for the next scan
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sel    <= decode(IR_RST);
      byp    <= 1'b0;
      usr_sh <= '0;
      upd_q  <= '0;
      stb_q  <= 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
      id_sh  <= '0;
`endif
    end else begin
      stb_q <= 1'b0;
      case (st)
        CAP_DR: begin
          sel    <= decode(ir_q);
          byp    <= 1'b0;
          usr_sh <= dr_capture_data;
`ifdef JTAG_TAP_IDCODE_EN
          id_sh  <= IDCODE;
`endif
        end
        SH_DR: begin
          case (sel)
            SEL_USR: usr_sh <= usr_nx;
`ifdef JTAG_TAP_IDCODE_EN
            SEL_ID:  id_sh  <= {tdi, id_sh[IDCODE_W-1:1]};
`endif
            default: byp    <= tdi;
          endcase
        end
        UPD_DR: begin
          if (sel == SEL_USR) begin
            upd_q <= usr_sh;
            stb_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (st == SH_IR) begin
      tdo = ir_sh[0];
    end else if (st == SH_DR) begin
      case (sel)
        SEL_USR: tdo = usr_sh[0];
`ifdef JTAG_TAP_IDCODE_EN
        SEL_ID:  tdo = id_sh[0];
`endif
        default: tdo = byp;
      endcase
    end
  end

  assign tdo_en           = (st == SH_DR) || (st == SH_IR);
  assign state            = st;
  assign ir               = ir_q;
  assign dr_update_data   = upd_q;
  assign dr_update_strobe = stb_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Scoreboard bench for jtag_tap_ctrl; expectations follow
// JTAG_TAP_IDCODE_EN the same way the design does.
module tb_jtag_tap_ctrl;

  localparam int IRW = 4;
  localparam int UW  = 8;
  localparam logic [31:0] IDC = 32'h1BA0_1477;
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [3:0] RST_IR = 4'h1;
  localparam bit         HAS_ID = 1'b1;
`else
  localparam logic [3:0] RST_IR = 4'hF;
  localparam bit         HAS_ID = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET;
  logic          tms;
  logic          tdi;
  logic          tdo;
  logic          tdo_en;
  logic [3:0]    state;
  logic [IRW-1:0] ir;
  logic [UW-1:0] cap;
  logic [UW-1:0] upd;
  logic          stb;

  int   n_vec = 0;
  int   n_err = 0;
  logic exp_q[$];

  always #5 CLK = ~CLK;

  jtag_tap_ctrl #(
    .IR_WIDTH      (IRW),
    .USER_DR_WIDTH (UW),
    .IDCODE        (IDC),
    .IDCODE_INSTR  (1),
    .USER_INSTR    (8)
  ) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .tms              (tms),
    .tdi              (tdi),
    .tdo              (tdo),
    .tdo_en           (tdo_en),
    .state            (state),
    .ir               (ir),
    .dr_capture_data  (cap),
    .dr_update_data   (upd),
    .dr_update_strobe (stb)
  );

  task automatic step(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic push_bits(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
  endtask

  // from RTI: full DR scan, optional pause after shift index pause_at-1
  task automatic dr_scan(input string nm, input int n,
                         input logic [63:0] din, input int pause_at,
                         input logic exp_stb);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    n_vec++;
    if (state !== 4'd4) begin
      n_err++;
      $display("FAIL %s enter_sh_dr state=%0d want 4", nm, state);
    end
    for (int i = 0; i < n; i++) begin
      logic e;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL %s bit%0d scoreboard empty", nm, i);
        e = 1'b0;
      end else begin
        e = exp_q.pop_front();
        if (tdo !== e || tdo_en !== 1'b1) begin
          n_err++;
          $display("FAIL %s bit%0d tdo=%b en=%b want tdo=%b en=1",
                   nm, i, tdo, tdo_en, e);
        end
      end
      step((i == n-1) || (i == pause_at-1), din[i]);
      if (i == pause_at-1 && i != n-1) begin
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        n_vec++;
        if (state !== 4'd6 || tdo_en !== 1'b0 || tdo !== 1'b0) begin
          n_err++;
          $display("FAIL %s pause state=%0d en=%b tdo=%b want 6/0/0",
                   nm, state, tdo_en, tdo);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
      end
    end
    step(1'b1, 1'b0);
    n_vec++;
    if (state !== 4'd8 || stb !== 1'b0) begin
      n_err++;
      $display("FAIL %s upd_dr state=%0d stb=%b want 8/0", nm, state, stb);
    end
    step(1'b0, 1'b0);
    n_vec++;
    if (stb !== exp_stb) begin
      n_err++;
      $display("FAIL %s strobe=%b want %b", nm, stb, exp_stb);
    end
    step(1'b0, 1'b0);
    n_vec++;
    if (stb !== 1'b0) begin
      n_err++;
      $display("FAIL %s strobe_len stb=%b want 0", nm, stb);
    end
  endtask

  // from RTI: IR scan of code, back to RTI
  task automatic ir_scan(input logic [IRW-1:0] code);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    push_bits(64'h1, IRW);
    for (int i = 0; i < IRW; i++) begin
      logic e;
      e = exp_q.pop_front();
      n_vec++;
      if (tdo !== e || state !== 4'd11) begin
        n_err++;
        $display("FAIL ir_scan bit%0d tdo=%b st=%0d want %b/11",
                 i, tdo, state, e);
      end
      step(i == IRW-1, code[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    n_vec++;
    if (ir !== code || state !== 4'd1) begin
      n_err++;
      $display("FAIL ir_scan ir=%h st=%0d want %h/1", ir, state, code);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    cap   = '0;
    step(1'b0, 1'b0);
    n_vec++;
    if (state !== 4'd0) begin
      n_err++;
      $display("FAIL reset_priority state=%0d want 0", state);
    end
    step(1'b1, 1'b0);
    RESET = 1'b0;
    n_vec++;
    if (state !== 4'd0 || ir !== RST_IR || tdo !== 1'b0 ||
        tdo_en !== 1'b0 || upd !== '0 || stb !== 1'b0) begin
      n_err++;
      $display("FAIL reset st=%0d ir=%h tdo=%b en=%b upd=%h stb=%b want 0/%h/0/0/0/0",
               state, ir, tdo, tdo_en, upd, stb, RST_IR);
    end
  endtask

  task automatic test_five_ones();
    step(1'b0, 1'b0);
    n_vec++;
    if (state !== 4'd1) begin
      n_err++;
      $display("FAIL rti state=%0d want 1", state);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    n_vec++;
    if (state !== 4'd0) begin
      n_err++;
      $display("FAIL five_ones_rti state=%0d want 0", state);
    end
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    n_vec++;
    if (state !== 4'd9) begin
      n_err++;
      $display("FAIL four_ones_sh state=%0d want 9", state);
    end
    step(1'b1, 1'b0);
    n_vec++;
    if (state !== 4'd0 || ir !== RST_IR) begin
      n_err++;
      $display("FAIL five_ones_sh state=%0d ir=%h want 0/%h",
               state, ir, RST_IR);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_idcode();
    if (HAS_ID) begin
      push_bits({32'h0, IDC}, 32);
      dr_scan("idcode", 32, 64'h0, 0, 1'b0);
    end else begin
      push_bits(64'h2, 2);
      dr_scan("no_idcode_byp", 2, 64'h3, 0, 1'b0);
    end
    n_vec++;
    if (ir !== RST_IR) begin
      n_err++;
      $display("FAIL idcode_ir ir=%h want %h", ir, RST_IR);
    end
  endtask

  task automatic test_user();
    ir_scan(4'h8);
    cap = 8'hA5;
    push_bits(64'hA5, 8);
    dr_scan("user", 8, 64'h3C, 0, 1'b1);
    n_vec++;
    if (upd !== 8'h3C) begin
      n_err++;
      $display("FAIL user_upd upd=%h want 3c", upd);
    end
  endtask

  task automatic test_pause();
    cap = 8'h96;
    push_bits(64'h96, 8);
    dr_scan("pause", 8, 64'h69, 4, 1'b1);
    n_vec++;
    if (upd !== 8'h69) begin
      n_err++;
      $display("FAIL pause_upd upd=%h want 69", upd);
    end
  endtask

  task automatic test_bypass();
    ir_scan(4'hF);
    push_bits(64'hD << 1, 4);
    dr_scan("bypass", 4, 64'hD, 0, 1'b0);
    ir_scan(4'h3);
    push_bits(64'h3 << 1, 3);
    dr_scan("other_code", 3, 64'h3, 0, 1'b0);
    n_vec++;
    if (upd !== 8'h69) begin
      n_err++;
      $display("FAIL bypass_upd upd=%h want 69", upd);
    end
  endtask

  task automatic test_idcode_instr();
    ir_scan(4'h1);
    if (HAS_ID) begin
      push_bits({32'h0, IDC}, 32);
      dr_scan("idcode_instr", 32, 64'h0, 0, 1'b0);
    end else begin
      push_bits(64'h5 << 1, 3);
      dr_scan("idcode_instr_byp", 3, 64'h5, 0, 1'b0);
    end
  endtask

  task automatic test_tlr_forces_ir();
    ir_scan(4'h8);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    n_vec++;
    if (ir !== RST_IR || state !== 4'd0) begin
      n_err++;
      $display("FAIL tlr_ir ir=%h st=%0d want %h/0", ir, state, RST_IR);
    end
    step(1'b0, 1'b0);
  endtask

  initial begin
    RESET = 1'b1;
    tms   = 1'b1;
    tdi   = 1'b0;
    cap   = '0;
    test_reset();
    step(1'b0, 1'b0);
    test_idcode();
    test_five_ones();
    test_user();
    test_pause();
    test_bypass();
    test_idcode_instr();
    test_tlr_forces_ir();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
